// File: rtl/sram_phase_sequencer.sv
// Sequences one shared SRAM port through idle/display, serial load, and an ordered
// chain of processing stages, with optional per-stage watchdog abort.
module sram_phase_sequencer #(
  parameter int NUM_STAGES    = 3,
  parameter int ADDR_W        = 18,
  parameter int DATA_W        = 16,
  parameter int LOAD_TIMEOUT  = 50000000,
  parameter int STAGE_TIMEOUT = 0
) (
  input  logic                                  Clock,
  input  logic                                  Reset,
  input  logic                                  Rx_line,
  input  logic [ADDR_W-1:0]                     Loader_address,
  input  logic [DATA_W-1:0]                     Loader_write_data,
  input  logic                                  Loader_we_n,
  input  logic [NUM_STAGES-1:0][ADDR_W-1:0]     Stage_address,
  input  logic [NUM_STAGES-1:0][DATA_W-1:0]     Stage_write_data,
  input  logic [NUM_STAGES-1:0]                 Stage_we_n,
  input  logic [ADDR_W-1:0]                     Display_address,
  input  logic [NUM_STAGES-1:0]                 Stage_finish,
  input  logic [NUM_STAGES-1:0]                 Stage_skip,
  output logic [ADDR_W-1:0]                     SRAM_address,
  output logic [DATA_W-1:0]                     SRAM_write_data,
  output logic                                  SRAM_we_n,
  output logic [NUM_STAGES-1:0]                 Stage_start,
  output logic                                  Loader_initialize,
  output logic                                  Loader_enable,
  output logic                                  Display_enable,
  output logic [$clog2(NUM_STAGES+2)-1:0]       Phase,
  output logic                                  Timeout_error
);

  localparam int PH_W  = $clog2(NUM_STAGES + 2);
  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int LT_W  = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;
  localparam int ST_W  = (STAGE_TIMEOUT > 1) ? $clog2(STAGE_TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STAGE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   stage_q, stage_d;
  logic [LT_W-1:0]    load_timer_q, load_timer_d;
  logic [ST_W-1:0]    stage_cnt_q, stage_cnt_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic               init_q, init_d;
  logic               enable_q, enable_d;
  logic               disp_q, disp_d;
  logic               tout_q, tout_d;
  logic               advance;
  int                 first_idx;
  logic [IDX_W:0]     sel;

  // Returns {found, index} of the lowest unskipped stage at or above 'first'.
  function automatic logic [IDX_W:0] find_stage(input logic [NUM_STAGES-1:0] skip,
                                                input int first);
    logic [IDX_W:0] r;
    r = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (i >= first && !skip[i]) r = {1'b1, IDX_W'(i)};
    end
    return r;
  endfunction

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      stage_q      <= '0;
      load_timer_q <= '0;
      stage_cnt_q  <= '0;
      phase_q      <= '0;
      init_q       <= 1'b0;
      enable_q     <= 1'b0;
      disp_q       <= 1'b1;
      tout_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      stage_q      <= stage_d;
      load_timer_q <= load_timer_d;
      stage_cnt_q  <= stage_cnt_d;
      phase_q      <= phase_d;
      init_q       <= init_d;
      enable_q     <= enable_d;
      disp_q       <= disp_d;
      tout_q       <= tout_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    stage_d      = stage_q;
    load_timer_d = load_timer_q;
    stage_cnt_d  = stage_cnt_q;
    phase_d      = phase_q;
    init_d       = 1'b0;
    enable_d     = 1'b0;
    disp_d       = disp_q;
    tout_d       = tout_q;
    advance      = 1'b0;
    first_idx    = 0;
    sel          = '0;

    case (state_q)
      S_IDLE: begin
        disp_d = 1'b1;
        if (!Rx_line) begin
          state_d      = S_LOAD;
          init_d       = 1'b1;
          disp_d       = 1'b0;
          load_timer_d = '0;
          tout_d       = 1'b0;
          phase_d      = PH_W'(1);
        end
      end
      S_LOAD: begin
        enable_d = init_q;
        // Loader activity restarts the idle window even on the terminal count.
        if (!Loader_we_n) begin
          load_timer_d = '0;
        end else if (load_timer_q == LT_W'(LOAD_TIMEOUT - 1)) begin
          advance   = 1'b1;
          first_idx = 0;
        end else begin
          load_timer_d = load_timer_q + LT_W'(1);
        end
      end
      S_STAGE: begin
        if (Stage_finish[stage_q]) begin
          advance   = 1'b1;
          first_idx = int'(stage_q) + 1;
        end else if (STAGE_TIMEOUT > 0 && stage_cnt_q == ST_W'(STAGE_TIMEOUT - 1)) begin
          state_d = S_IDLE;
          phase_d = '0;
          disp_d  = 1'b1;
          tout_d  = 1'b1;
        end else if (STAGE_TIMEOUT > 0) begin
          stage_cnt_d = stage_cnt_q + ST_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        phase_d = '0;
        disp_d  = 1'b1;
      end
    endcase

    // Stage selection samples the skip mask only here.
    if (advance) begin
      sel = find_stage(Stage_skip, first_idx);
      if (sel[IDX_W]) begin
        state_d     = S_STAGE;
        stage_d     = sel[IDX_W-1:0];
        stage_cnt_d = '0;
        phase_d     = PH_W'(2) + PH_W'(sel[IDX_W-1:0]);
      end else begin
        state_d = S_IDLE;
        phase_d = '0;
        disp_d  = 1'b1;
      end
    end
  end

  always_comb begin
    Stage_start = '0;
    if (state_q == S_STAGE) Stage_start[stage_q] = 1'b1;
  end

  always_comb begin
    SRAM_address    = Display_address;
    SRAM_write_data = '0;
    SRAM_we_n       = 1'b1;
    case (state_q)
      S_LOAD: begin
        SRAM_address    = Loader_address;
        SRAM_write_data = Loader_write_data;
        SRAM_we_n       = Loader_we_n;
      end
      S_STAGE: begin
        SRAM_address    = Stage_address[stage_q];
        SRAM_write_data = Stage_write_data[stage_q];
        SRAM_we_n       = Stage_we_n[stage_q];
      end
      default: ;
    endcase
  end

  assign Phase             = phase_q;
  assign Loader_initialize = init_q;
  assign Loader_enable     = enable_q;
  assign Display_enable    = disp_q;
  assign Timeout_error     = tout_q;

endmodule

// File: tb/tb_sram_phase_sequencer.sv
// Bench for sram_phase_sequencer: a scoreboard of expected Stage_start rises
// (stage, cycle) plus directed checks of load, skip, timeout and reset behaviour.
module tb_sram_phase_sequencer;

  localparam int NS     = 3;
  localparam int AW     = 18;
  localparam int DW     = 16;
  localparam int LT     = 100;
  localparam int STO    = 50;
  localparam int PHW    = $clog2(NS + 2);

  localparam logic [AW-1:0] LOADER_ADDR = 18'h11111;
  localparam logic [DW-1:0] LOADER_DATA = 16'hAAAA;
  localparam logic [AW-1:0] DISP_ADDR   = 18'h30303;

  logic                      Clock;
  logic                      Reset;
  logic                      Rx_line;
  logic [AW-1:0]             Loader_address;
  logic [DW-1:0]             Loader_write_data;
  logic                      Loader_we_n;
  logic [NS-1:0][AW-1:0]     Stage_address;
  logic [NS-1:0][DW-1:0]     Stage_write_data;
  logic [NS-1:0]             Stage_we_n;
  logic [AW-1:0]             Display_address;
  logic [NS-1:0]             Stage_finish;
  logic [NS-1:0]             Stage_skip;
  logic [AW-1:0]             SRAM_address;
  logic [DW-1:0]             SRAM_write_data;
  logic                      SRAM_we_n;
  logic [NS-1:0]             Stage_start;
  logic                      Loader_initialize;
  logic                      Loader_enable;
  logic                      Display_enable;
  logic [PHW-1:0]            Phase;
  logic                      Timeout_error;

  sram_phase_sequencer #(
    .NUM_STAGES(NS), .ADDR_W(AW), .DATA_W(DW),
    .LOAD_TIMEOUT(LT), .STAGE_TIMEOUT(STO)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Rx_line(Rx_line),
    .Loader_address(Loader_address), .Loader_write_data(Loader_write_data),
    .Loader_we_n(Loader_we_n),
    .Stage_address(Stage_address), .Stage_write_data(Stage_write_data),
    .Stage_we_n(Stage_we_n), .Display_address(Display_address),
    .Stage_finish(Stage_finish), .Stage_skip(Stage_skip),
    .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data),
    .SRAM_we_n(SRAM_we_n), .Stage_start(Stage_start),
    .Loader_initialize(Loader_initialize), .Loader_enable(Loader_enable),
    .Display_enable(Display_enable), .Phase(Phase), .Timeout_error(Timeout_error)
  );

  typedef struct {
    int stage;
    int cycle;
  } exp_t;

  exp_t          exp_q[$];
  int            check_count = 0;
  int            error_count = 0;
  int            cycle_count = 0;
  logic [NS-1:0] prev_start  = '0;
  logic [NS-1:0] stage_we_pat = 3'b010;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock) cycle_count++;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)",
               tag, observed, expected, cycle_count);
    end
  endtask

  function automatic logic [AW-1:0] stage_addr(input int k);
    return AW'(18'h20000 + k * 18'h111);
  endfunction

  function automatic logic [DW-1:0] stage_data(input int k);
    return DW'(16'hD000 + k);
  endfunction

  // Scoreboard: every Stage_start rise must match the next expected (stage, cycle).
  always @(negedge Clock) begin
    if (Stage_start != prev_start) begin
      checkOutput("onehot", 64'($countones(Stage_start) <= 1), 64'd1);
      for (int k = 0; k < NS; k++) begin
        if (Stage_start[k] && !prev_start[k]) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_start", 64'(k), 64'hFF);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            checkOutput("start_idx", 64'(k), 64'(e.stage));
            checkOutput("start_cycle", 64'(cycle_count), 64'(e.cycle));
          end
        end
      end
    end
    prev_start = Stage_start;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic waitCycle();
    @(posedge Clock);
    #1;
  endtask

  task automatic applyStimulus(input logic rx, input logic we_n,
                               input logic [NS-1:0] fin);
    Rx_line      = rx;
    Loader_we_n  = we_n;
    Stage_finish = fin;
  endtask

  task automatic startLoad(output int e0);
    applyStimulus(1'b0, 1'b1, '0);
    waitCycle();
    Rx_line = 1'b1;
    e0 = cycle_count;
    checkOutput("init_pulse", Loader_initialize, 1);
    checkOutput("enable_early", Loader_enable, 0);
    checkOutput("phase_load", Phase, 1);
    checkOutput("disp_load", Display_enable, 0);
    checkOutput("tout_clear", Timeout_error, 0);
    checkOutput("sram_addr_load", SRAM_address, LOADER_ADDR);
    checkOutput("sram_data_load", SRAM_write_data, LOADER_DATA);
    waitCycle();
    checkOutput("init_drop", Loader_initialize, 0);
    checkOutput("enable_pulse", Loader_enable, 1);
    waitCycle();
    checkOutput("enable_drop", Loader_enable, 0);
  endtask

  task automatic pulseWe(output int at_cycle);
    Loader_we_n = 1'b0;
    #1;
    checkOutput("sram_we_load", SRAM_we_n, 0);
    waitCycle();
    Loader_we_n = 1'b1;
    at_cycle = cycle_count;
  endtask

  task automatic waitStart(input int k, output int s);
    for (int i = 0; i < 400 && !Stage_start[k]; i++) waitCycle();
    checkOutput("start_seen", Stage_start[k], 1);
    s = cycle_count;
  endtask

  // Runs stage k for 10 cycles, with a stray finish and Rx low mid-stage.
  task automatic runStage(input int k, input int nxt);
    int s;
    int other;
    waitStart(k, s);
    other = (k + 1) % NS;
    checkOutput("phase_stage", Phase, 64'(2 + k));
    checkOutput("sram_addr_stage", SRAM_address, stage_addr(k));
    checkOutput("sram_data_stage", SRAM_write_data, stage_data(k));
    checkOutput("sram_we_stage", SRAM_we_n, stage_we_pat[k]);
    checkOutput("disp_stage", Display_enable, 0);
    repeat (3) waitCycle();
    Stage_finish[other] = 1'b1;
    Rx_line = 1'b0;
    waitCycle();
    Stage_finish[other] = 1'b0;
    Rx_line = 1'b1;
    checkOutput("stray_finish_phase", Phase, 64'(2 + k));
    checkOutput("rx_ignored", Loader_initialize, 0);
    repeat (5) waitCycle();
    Stage_finish[k] = 1'b1;
    if (nxt >= 0) exp_q.push_back('{stage: nxt, cycle: s + 10});
    waitCycle();
    Stage_finish[k] = 1'b0;
    if (nxt < 0) begin
      checkOutput("phase_done", Phase, 0);
      checkOutput("disp_done", Display_enable, 1);
      checkOutput("sram_addr_idle", SRAM_address, DISP_ADDR);
      checkOutput("sram_we_idle", SRAM_we_n, 1);
    end else begin
      checkOutput("phase_next", Phase, 64'(2 + nxt));
    end
  endtask

  initial begin
    int e0;
    int last;
    int s;

    Reset             = 1'b1;
    Rx_line           = 1'b1;
    Loader_we_n       = 1'b1;
    Loader_address    = LOADER_ADDR;
    Loader_write_data = LOADER_DATA;
    Display_address   = DISP_ADDR;
    Stage_finish      = '0;
    Stage_skip        = '0;
    Stage_we_n        = stage_we_pat;
    for (int k = 0; k < NS; k++) begin
      Stage_address[k]    = stage_addr(k);
      Stage_write_data[k] = stage_data(k);
    end

    repeat (3) waitCycle();
    checkOutput("rst_phase", Phase, 0);
    checkOutput("rst_disp", Display_enable, 1);
    checkOutput("rst_start", Stage_start, 0);
    checkOutput("rst_init", Loader_initialize, 0);
    checkOutput("rst_enable", Loader_enable, 0);
    checkOutput("rst_tout", Timeout_error, 0);
    checkOutput("rst_sram_addr", SRAM_address, DISP_ADDR);
    checkOutput("rst_sram_data", SRAM_write_data, 0);
    checkOutput("rst_sram_we", SRAM_we_n, 1);
    Reset = 1'b0;
    repeat (2) waitCycle();

    $display("[TB] load with loader activity, then full 3-stage run");
    startLoad(e0);
    pulseWe(last);
    for (int p = 0; p < 4; p++) begin
      repeat (79) waitCycle();
      pulseWe(last);
    end
    repeat (99) waitCycle();
    pulseWe(last);
    checkOutput("coincident_keeps_load", Phase, 1);
    checkOutput("coincident_no_start", Stage_start, 0);
    exp_q.push_back('{stage: 0, cycle: last + 100});
    runStage(0, 1);
    runStage(1, 2);
    runStage(2, -1);

    $display("[TB] skip mask 010");
    Stage_skip = 3'b010;
    startLoad(e0);
    exp_q.push_back('{stage: 0, cycle: e0 + 100});
    runStage(0, 2);
    runStage(2, -1);

    $display("[TB] skip mask 111");
    Stage_skip = 3'b111;
    startLoad(e0);
    repeat (97) waitCycle();
    checkOutput("allskip_still_load", Phase, 1);
    waitCycle();
    checkOutput("allskip_phase", Phase, 0);
    checkOutput("allskip_disp", Display_enable, 1);
    checkOutput("allskip_start", Stage_start, 0);
    Stage_skip = 3'b000;
    repeat (3) waitCycle();

    $display("[TB] stage 1 watchdog");
    startLoad(e0);
    exp_q.push_back('{stage: 0, cycle: e0 + 100});
    runStage(0, 1);
    waitStart(1, s);
    repeat (49) waitCycle();
    checkOutput("tout_hold", Stage_start, 3'b010);
    waitCycle();
    checkOutput("tout_start_drop", Stage_start, 0);
    checkOutput("tout_flag", Timeout_error, 1);
    checkOutput("tout_phase", Phase, 0);
    repeat (20) waitCycle();
    checkOutput("tout_sticky", Timeout_error, 1);
    checkOutput("tout_no_stage2", Stage_start, 0);

    $display("[TB] reset during stage 1");
    startLoad(e0);
    exp_q.push_back('{stage: 0, cycle: e0 + 100});
    runStage(0, 1);
    waitStart(1, s);
    repeat (5) waitCycle();
    #2;
    Reset = 1'b1;
    #1;
    checkOutput("arst_start", Stage_start, 0);
    checkOutput("arst_phase", Phase, 0);
    checkOutput("arst_disp", Display_enable, 1);
    checkOutput("arst_sram_addr", SRAM_address, DISP_ADDR);
    checkOutput("arst_sram_we", SRAM_we_n, 1);
    repeat (2) waitCycle();
    Reset = 1'b0;
    Stage_finish = 3'b111;
    repeat (3) waitCycle();
    Stage_finish = 3'b000;
    checkOutput("post_rst_phase", Phase, 0);
    checkOutput("post_rst_start", Stage_start, 0);
    checkOutput("post_rst_init", Loader_initialize, 0);
    repeat (3) waitCycle();
    checkOutput("queue_empty", 64'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
